// File: rtl/gpu_pkg.sv
// Types and defaults shared by the thread-level blocks: scheduler state encodings,
// load/store unit state, and the default operand widths.
package gpu_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_watchdog.sv
// Cycle counter that flags expiry after TIMEOUT_CYCLES enabled counts since the last clear.
// With TIMEOUT_CYCLES = 0 it reduces to a constant-zero expired flag.
module lsu_watchdog #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic w_unused;
    assign w_unused  = &{1'b0, clk, reset, i_clear, i_count_en};
    assign o_expired = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_count;

    // Expiry is seen during the final counted cycle, so the owner can act on that same edge.
    assign o_expired = i_count_en && (r_count == CW'(TIMEOUT_CYCLES - 1));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
      if (reset || i_clear) begin
        r_count <= '0;
      end else if (i_count_en && !o_expired) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: runs one valid/ready memory transaction per LDR/STR
// and hands the loaded value back to the register file through lsu_out.
module thread_lsu
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS      = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS      = DEFAULT_DATA_BITS,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [ADDR_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_t             r_state;
  lsu_state_t             w_next;
  logic                   r_is_read;
  logic                   r_read_valid;
  logic                   r_write_valid;
  logic [ADDR_BITS-1:0]   r_read_address;
  logic [ADDR_BITS-1:0]   r_write_address;
  logic [DATA_BITS-1:0]   r_write_data;
  logic [DATA_BITS-1:0]   r_lsu_out;
  logic                   r_lsu_error;

  logic w_start;
  logic w_ready;
  logic w_expired;
  logic w_issue;
  logic w_complete;
  logic w_abort;

  assign w_start = (core_state == CORE_REQUEST) &&
                   (decoded_mem_read_enable || decoded_mem_write_enable);
  // Only the ready of the operation in flight matters.
  assign w_ready = r_is_read ? mem_read_ready : mem_write_ready;

  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (enable && (r_state == LSU_REQUESTING)),
    .i_count_en(enable && (r_state == LSU_WAITING)),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LSU_IDLE;
    end else if (enable) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      LSU_IDLE:       if (w_start) w_next = LSU_REQUESTING;
      LSU_REQUESTING: w_next = LSU_WAITING;
      LSU_WAITING:    if (w_ready || w_expired) w_next = LSU_DONE;
      LSU_DONE:       if (core_state == CORE_UPDATE) w_next = LSU_IDLE;
      default:        w_next = LSU_IDLE;
    endcase
  end

  always_comb begin
    w_issue    = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    if (enable) begin
      case (r_state)
        LSU_REQUESTING: w_issue = 1'b1;
        LSU_WAITING: begin
          // Ready on the expiry cycle takes priority over the timeout.
          if (w_ready)        w_complete = 1'b1;
          else if (w_expired) w_abort    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_read       <= 1'b0;
      r_read_valid    <= 1'b0;
      r_write_valid   <= 1'b0;
      r_read_address  <= '0;
      r_write_address <= '0;
      r_write_data    <= '0;
      r_lsu_out       <= '0;
      r_lsu_error     <= 1'b0;
    end else if (enable) begin
      // A simultaneous LDR/STR decode resolves to the read.
      if (r_state == LSU_IDLE && w_start) begin
        r_is_read <= decoded_mem_read_enable;
      end
      if (w_issue) begin
        if (r_is_read) begin
          r_read_valid   <= 1'b1;
          r_read_address <= rs;
        end else begin
          r_write_valid   <= 1'b1;
          r_write_address <= rs;
          r_write_data    <= rt;
        end
      end
      if (w_complete) begin
        if (r_is_read) r_lsu_out <= mem_read_data;
        r_read_valid  <= 1'b0;
        r_write_valid <= 1'b0;
      end
      if (w_abort) begin
        if (r_is_read) r_lsu_out <= '0;
        r_read_valid  <= 1'b0;
        r_write_valid <= 1'b0;
        r_lsu_error   <= 1'b1;
      end
    end
  end

  assign lsu_state         = r_state;
  assign mem_read_valid    = r_read_valid;
  assign mem_read_address  = r_read_address;
  assign mem_write_valid   = r_write_valid;
  assign mem_write_address = r_write_address;
  assign mem_write_data    = r_write_data;
  assign lsu_out           = r_lsu_out;
  assign lsu_error         = r_lsu_error;

endmodule

// File: tb/tb_thread_lsu.sv
// Scoreboard bench for thread_lsu: one instance without a watchdog and one with
// TIMEOUT_CYCLES=4 share the instruction stream, each with its own memory responder.
module tb_thread_lsu;
  import gpu_pkg::*;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] hold;
    logic [7:0] out;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic       active;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] hold;
    logic       unstable;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, enable, rd_en, wr_en, force_rdy;
  logic [2:0] core_state;
  logic [7:0] rs, rt, rdata;

  logic       m_rv, m_wv, m_rrdy, m_wrdy, m_err;
  logic [7:0] m_ra, m_wa, m_wd, m_out;
  logic [1:0] m_st;
  logic       w_rv, w_wv, w_rrdy, w_wrdy, w_err;
  logic [7:0] w_ra, w_wa, w_wd, w_out;
  logic [1:0] w_st;

  logic m_rrdy_mdl = 1'b0, m_wrdy_mdl = 1'b0, w_rrdy_mdl = 1'b0, w_wrdy_mdl = 1'b0;
  int   m_lat = 0, w_lat = 0, m_cnt = 0, w_cnt = 0;

  exp_t m_q[$];
  exp_t w_q[$];
  obs_t m_obs = '0, w_obs = '0;
  logic [1:0] m_prev = 2'd0, w_prev = 2'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_rrdy = m_rrdy_mdl | force_rdy;
  assign m_wrdy = m_wrdy_mdl | force_rdy;
  assign w_rrdy = w_rrdy_mdl | force_rdy;
  assign w_wrdy = w_wrdy_mdl | force_rdy;

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(m_rv), .mem_read_address(m_ra), .mem_read_ready(m_rrdy),
    .mem_read_data(rdata),
    .mem_write_valid(m_wv), .mem_write_address(m_wa), .mem_write_data(m_wd),
    .mem_write_ready(m_wrdy),
    .lsu_state(m_st), .lsu_out(m_out), .lsu_error(m_err)
  );

  thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut_wd (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(w_rv), .mem_read_address(w_ra), .mem_read_ready(w_rrdy),
    .mem_read_data(rdata),
    .mem_write_valid(w_wv), .mem_write_address(w_wa), .mem_write_data(w_wd),
    .mem_write_ready(w_wrdy),
    .lsu_state(w_st), .lsu_out(w_out), .lsu_error(w_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] data, input logic [7:0] hold,
                              input logic [7:0] out, input logic err);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = addr; e.data = data;
    e.hold = hold; e.out = out; e.err = err;
    return e;
  endfunction

  // Records the request as seen on the bus: kind, address/data at rise, cycles held, stability.
  function automatic obs_t track(input obs_t o, input logic rv, input logic [7:0] ra,
                                 input logic wv, input logic [7:0] wa, input logic [7:0] wd);
    obs_t n = o;
    if (rv || wv) begin
      if (!o.active) begin
        n.active = 1'b1; n.rd = rv; n.wr = wv;
        n.addr = rv ? ra : wa; n.data = wv ? wd : 8'h00;
        n.hold = 8'd1; n.unstable = 1'b0;
      end else begin
        n.hold = o.hold + 8'd1;
        n.rd = o.rd | rv; n.wr = o.wr | wv;
        if ((rv ? ra : wa) != o.addr || (wv && wd != o.data)) n.unstable = 1'b1;
      end
    end else begin
      n.active = 1'b0;
    end
    return n;
  endfunction

  task automatic compare_tx(input string p, input exp_t e, input obs_t o,
                            input logic [7:0] out, input logic err);
    check({p, "_read_issued"},  32'(o.rd),       32'(e.rd));
    check({p, "_write_issued"}, 32'(o.wr),       32'(e.wr));
    check({p, "_address"},      32'(o.addr),     32'(e.addr));
    check({p, "_wdata"},        32'(o.data),     32'(e.data));
    check({p, "_valid_cycles"}, 32'(o.hold),     32'(e.hold));
    check({p, "_bus_stable"},   32'(o.unstable), 32'd0);
    check({p, "_lsu_out"},      32'(out),        32'(e.out));
    check({p, "_lsu_error"},    32'(err),        32'(e.err));
  endtask

  // Memory responders: ready pulses on the (lat+1)-th cycle of valid; lat < 0 means never.
  always @(negedge clk) begin
    if (m_rv || m_wv) begin
      m_rrdy_mdl = m_rv && m_lat >= 0 && m_cnt == m_lat;
      m_wrdy_mdl = m_wv && m_lat >= 0 && m_cnt == m_lat;
      m_cnt++;
    end else begin
      m_rrdy_mdl = 1'b0; m_wrdy_mdl = 1'b0; m_cnt = 0;
    end
    if (w_rv || w_wv) begin
      w_rrdy_mdl = w_rv && w_lat >= 0 && w_cnt == w_lat;
      w_wrdy_mdl = w_wv && w_lat >= 0 && w_cnt == w_lat;
      w_cnt++;
    end else begin
      w_rrdy_mdl = 1'b0; w_wrdy_mdl = 1'b0; w_cnt = 0;
    end
  end

  // Scoreboard monitors: each entry into DONE retires one expected transaction.
  always @(negedge clk) begin
    if (m_st == LSU_DONE && m_prev != LSU_DONE) begin
      if (m_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_unexpected_done: got DONE, expected no pending transaction");
      end else begin
        compare_tx("m", m_q.pop_front(), m_obs, m_out, m_err);
      end
    end
    m_obs  = track(m_obs, m_rv, m_ra, m_wv, m_wa, m_wd);
    m_prev = m_st;
  end

  always @(negedge clk) begin
    if (w_st == LSU_DONE && w_prev != LSU_DONE) begin
      if (w_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL w_unexpected_done: got DONE, expected no pending transaction");
      end else begin
        compare_tx("w", w_q.pop_front(), w_obs, w_out, w_err);
      end
    end
    w_obs  = track(w_obs, w_rv, w_ra, w_wv, w_wa, w_wd);
    w_prev = w_st;
  end

  task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rdat, input int ml, input int wl);
    m_lat = ml; w_lat = wl;
    rd_en = rd; wr_en = wr; rs = a; rt = d; rdata = rdat;
    core_state = CORE_REQUEST;
    @(posedge clk); @(negedge clk);
    core_state = CORE_WAIT;
  endtask

  task automatic finish_instr(output int m_cyc);
    int cyc = 1;
    m_cyc = 0;
    while (!(m_st == LSU_DONE && w_st == LSU_DONE) && cyc < 64) begin
      if (m_st == LSU_DONE && m_cyc == 0) m_cyc = cyc;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    if (m_st == LSU_DONE && m_cyc == 0) m_cyc = cyc;
    check("both_reach_done", {30'd0, m_st == LSU_DONE, w_st == LSU_DONE}, 32'd3);
    core_state = CORE_UPDATE;
    @(posedge clk); @(negedge clk);
    core_state = CORE_IDLE; rd_en = 1'b0; wr_en = 1'b0;
    check("m_idle_after_update", 32'(m_st), 32'(LSU_IDLE));
    check("w_idle_after_update", 32'(w_st), 32'(LSU_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish within bound");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    reset = 1'b1; enable = 1'b1; core_state = CORE_IDLE; rd_en = 1'b0; wr_en = 1'b0;
    rs = 8'h00; rt = 8'h00; rdata = 8'h00; force_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_state", 32'(m_st), 32'(LSU_IDLE));
    check("rst_m_valids", {30'd0, m_rv, m_wv}, 32'd0);
    check("rst_m_addr_data", {8'd0, m_ra, m_wa, m_wd}, 32'd0);
    check("rst_m_out_err", {23'd0, m_err, m_out}, 32'd0);
    check("rst_w_state", 32'(w_st), 32'(LSU_IDLE));
    check("rst_w_out_err", {23'd0, w_err, w_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Load, zero wait: DONE on the third cycle counting the REQUEST cycle.
    m_q.push_back(mk(1, 0, 8'h10, 8'h00, 8'd1, 8'hA5, 0));
    w_q.push_back(mk(1, 0, 8'h10, 8'h00, 8'd1, 8'hA5, 0));
    issue(1, 0, 8'h10, 8'h00, 8'hA5, 0, 0);
    check("req_to_requesting", 32'(m_st), 32'(LSU_REQUESTING));
    finish_instr(cyc);
    check("load_latency", 32'(cyc), 32'd3);

    // Store held five cycles; lsu_out keeps the previous load.
    m_q.push_back(mk(0, 1, 8'h20, 8'h3C, 8'd5, 8'hA5, 0));
    w_q.push_back(mk(0, 1, 8'h20, 8'h3C, 8'd3, 8'hA5, 0));
    issue(0, 1, 8'h20, 8'h3C, 8'h00, 4, 2);
    finish_instr(cyc);

    // Both decode enables: read only, write bus idle.
    m_q.push_back(mk(1, 0, 8'h07, 8'h00, 8'd2, 8'hC3, 0));
    w_q.push_back(mk(1, 0, 8'h07, 8'h00, 8'd2, 8'hC3, 0));
    issue(1, 1, 8'h07, 8'h99, 8'hC3, 1, 1);
    finish_instr(cyc);

    // Reset while WAITING with valid high; later ready is ignored.
    issue(1, 0, 8'h30, 8'h00, 8'hE1, -1, -1);
    @(posedge clk); @(negedge clk);
    check("pre_reset_waiting", 32'(m_st), 32'(LSU_WAITING));
    check("pre_reset_valid", 32'(m_rv), 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; core_state = CORE_IDLE; rd_en = 1'b0;
    check("midrst_m_state", 32'(m_st), 32'(LSU_IDLE));
    check("midrst_m_valid_addr", {23'd0, m_rv, m_ra}, 32'd0);
    check("midrst_m_out", 32'(m_out), 32'd0);
    check("midrst_w_state_valid", {29'd0, w_st, w_rv}, 32'd0);
    force_rdy = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    force_rdy = 1'b0;
    check("late_ready_state", 32'(m_st), 32'(LSU_IDLE));
    check("late_ready_out", {23'd0, m_rv, m_out}, 32'd0);

    // enable low for three cycles in WAITING while ready is high.
    m_q.push_back(mk(1, 0, 8'h44, 8'h00, 8'd4, 8'h5E, 0));
    w_q.push_back(mk(1, 0, 8'h44, 8'h00, 8'd4, 8'h5E, 0));
    issue(1, 0, 8'h44, 8'h00, 8'h5E, -1, -1);
    @(posedge clk); @(negedge clk);
    enable = 1'b0; force_rdy = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("frozen_m_state", 32'(m_st), 32'(LSU_WAITING));
      check("frozen_m_out", {23'd0, m_rv, m_out}, 32'h100);
      check("frozen_w_state", 32'(w_st), 32'(LSU_WAITING));
    end
    enable = 1'b1;
    finish_instr(cyc);
    force_rdy = 1'b0;

    // Ready on the watchdog expiry cycle wins: no error.
    m_q.push_back(mk(1, 0, 8'h50, 8'h00, 8'd4, 8'h6B, 0));
    w_q.push_back(mk(1, 0, 8'h50, 8'h00, 8'd4, 8'h6B, 0));
    issue(1, 0, 8'h50, 8'h00, 8'h6B, 3, 3);
    finish_instr(cyc);

    // Watchdog timeout on the TIMEOUT_CYCLES=4 instance; the other completes late.
    m_q.push_back(mk(1, 0, 8'h60, 8'h00, 8'd6, 8'h77, 0));
    w_q.push_back(mk(1, 0, 8'h60, 8'h00, 8'd4, 8'h00, 1));
    issue(1, 0, 8'h60, 8'h00, 8'h77, 5, -1);
    finish_instr(cyc);

    // Next instruction: error flag stays sticky.
    m_q.push_back(mk(0, 1, 8'h61, 8'h12, 8'd1, 8'h77, 0));
    w_q.push_back(mk(0, 1, 8'h61, 8'h12, 8'd1, 8'h00, 1));
    issue(0, 1, 8'h61, 8'h12, 8'h00, 0, 0);
    finish_instr(cyc);
    check("sticky_error", 32'(w_err), 32'd1);

    repeat (3) @(negedge clk);
    check("m_scoreboard_drained", 32'(m_q.size()), 32'd0);
    check("w_scoreboard_drained", 32'(w_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
